// File: rtl/serial_loader.sv
// serial_loader
//   Serial bus initiator that loads memory images into the S100/Altair memory
//   map while the CPU is held off the bus. A UART line (8N1, LSB first) carries
//   framed load commands:
//     START_BYTE, ADH, ADL, LNH, LNL, <LN data bytes>, CSUM
//   Each data byte becomes one single-cycle write strobe on addr/data_out/we.
//   CSUM makes the 8-bit sum of ADH..CSUM equal zero; START_BYTE is excluded.
//
// Ports
//   clk             in   system clock (single domain)
//   reset           in   synchronous, active-high
//   rx              in   asynchronous serial input, idle high
//   addr            out  memory write address
//   data_out        out  memory write data
//   we              out  one-clk write strobe
//   busy            out  frame in progress (top level holds CPU, grants bus)
//   done            out  one-clk pulse on frame completion with good checksum
//   err             out  sticky: bad checksum or framing error inside a frame
//   rx_state_dbg    out  receiver FSM state (debug)
//   frame_state_dbg out  frame FSM state (debug)
//
// Internal handshake: the receiver presents rx_byte with a one-clk rx_valid
// pulse (or rx_ferr on a bad stop bit). There is no ready/backpressure: the
// frame FSM consumes every pulse in the cycle it appears, which is always
// possible because bytes arrive at least ten bit times apart.

module serial_loader #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  START_BYTE   = 8'h4C
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [15:0] addr,
  output logic [7:0]  data_out,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  rx_state_dbg,
  output logic [2:0]  frame_state_dbg
);

  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  // ---------------------------------------------------------------------
  // RX front end
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t      rx_state, rx_state_n;
  logic           rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]  rx_cnt, rx_cnt_n;
  logic [2:0]     rx_bitn, rx_bitn_n;
  logic [7:0]     rx_shift, rx_shift_n;
  logic           rx_valid, rx_ferr;
  logic [7:0]     rx_byte;

  assign rx_byte      = rx_shift;
  assign rx_state_dbg = rx_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bitn  <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta  <= rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bitn  <= rx_bitn_n;
      rx_shift <= rx_shift_n;
    end
  end

  // rx_cnt counts clocks since the last reference point (start edge or
  // previous sample); a sample is taken when it reaches HALF / CLKS_PER_BIT.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bitn_n  = rx_bitn;
    rx_shift_n = rx_shift;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_n = RX_START;
          rx_cnt_n   = CW'(1);
        end
      end
      RX_START: begin
        if (rx_cnt == CW'(HALF)) begin
          if (rx_sync) begin
            rx_state_n = RX_IDLE;        // glitch, not a real start bit
          end else begin
            rx_state_n = RX_DATA;
            rx_cnt_n   = CW'(1);
            rx_bitn_n  = '0;
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == CW'(CLKS_PER_BIT)) begin
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          rx_cnt_n   = CW'(1);
          if (rx_bitn == 3'd7) rx_state_n = RX_STOP;
          else                 rx_bitn_n  = rx_bitn + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == CW'(CLKS_PER_BIT)) begin
          if (rx_sync) begin
            rx_valid   = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_ferr    = 1'b1;
            rx_state_n = RX_WAIT_HIGH;   // line must recover before next start
          end
        end else begin
          rx_cnt_n = rx_cnt + CW'(1);
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    F_IDLE, F_ADH, F_ADL, F_LNH, F_LNL, F_DATA, F_CSUM
  } frame_state_t;

  frame_state_t fstate, fstate_n;
  logic [15:0]  addr_n, remain, remain_n;
  logic [7:0]   data_n, csum, csum_n, len_hi, len_hi_n;
  logic         we_n, busy_n, done_n, err_n;

  assign frame_state_dbg = fstate;

  always_ff @(posedge clk) begin
    if (reset) begin
      fstate   <= F_IDLE;
      addr     <= '0;
      data_out <= '0;
      we       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      csum     <= '0;
      len_hi   <= '0;
      remain   <= '0;
    end else begin
      fstate   <= fstate_n;
      addr     <= addr_n;
      data_out <= data_n;
      we       <= we_n;
      busy     <= busy_n;
      done     <= done_n;
      err      <= err_n;
      csum     <= csum_n;
      len_hi   <= len_hi_n;
      remain   <= remain_n;
    end
  end

  always_comb begin
    fstate_n = fstate;
    addr_n   = addr;
    data_n   = data_out;
    we_n     = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;
    err_n    = err;
    csum_n   = csum;
    len_hi_n = len_hi;
    remain_n = remain;

    // Post-increment after the strobe so the RAM sees the written address
    // at its capture edge; 16-bit arithmetic wraps FFFF -> 0000.
    if (we) addr_n = addr + 16'd1;

    if (rx_ferr && busy) begin
      err_n    = 1'b1;
      busy_n   = 1'b0;
      fstate_n = F_IDLE;
    end else if (rx_valid) begin
      unique case (fstate)
        F_IDLE: begin
          if (rx_byte == START_BYTE) begin
            fstate_n = F_ADH;
            busy_n   = 1'b1;
            err_n    = 1'b0;
            csum_n   = '0;
          end
        end
        F_ADH: begin
          addr_n   = {rx_byte, addr[7:0]};
          csum_n   = csum + rx_byte;
          fstate_n = F_ADL;
        end
        F_ADL: begin
          addr_n   = {addr[15:8], rx_byte};
          csum_n   = csum + rx_byte;
          fstate_n = F_LNH;
        end
        F_LNH: begin
          len_hi_n = rx_byte;
          csum_n   = csum + rx_byte;
          fstate_n = F_LNL;
        end
        F_LNL: begin
          remain_n = {len_hi, rx_byte};
          csum_n   = csum + rx_byte;
          fstate_n = ({len_hi, rx_byte} == 16'd0) ? F_CSUM : F_DATA;
        end
        F_DATA: begin
          data_n   = rx_byte;
          we_n     = 1'b1;
          csum_n   = csum + rx_byte;
          remain_n = remain - 16'd1;
          if (remain == 16'd1) fstate_n = F_CSUM;
        end
        F_CSUM: begin
          if (8'(csum + rx_byte) == 8'd0) done_n = 1'b1;
          else                            err_n  = 1'b1;
          busy_n   = 1'b0;
          fstate_n = F_IDLE;
        end
        default: fstate_n = F_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_loader.sv
module tb_serial_loader;

  localparam int         CPB   = 4;
  localparam logic [7:0] START = 8'h4C;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic        we, busy, done, err;
  logic [2:0]  rx_state_dbg, frame_state_dbg;

  always #5 clk = ~clk;

  serial_loader #(.CLKS_PER_BIT(CPB), .START_BYTE(START)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .addr(addr), .data_out(data_out), .we(we),
    .busy(busy), .done(done), .err(err),
    .rx_state_dbg(rx_state_dbg), .frame_state_dbg(frame_state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];        // expected writes {addr, data}
  int          total = 0;
  int          bad = 0;
  int          done_seen = 0;
  int          exp_done = 0;
  logic [15:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  logic [7:0]  pay[0:15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference checksum: negated 8-bit sum of header and payload bytes.
  function automatic logic [7:0] model_cs(input logic [15:0] a, input int n);
    int s;
    s = a[15:8] + a[7:0] + ((n >> 8) & 255) + (n & 255);
    for (int i = 0; i < n; i++) s += pay[i];
    return 8'((256 - (s % 256)) % 256);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_frame(input logic [15:0] a, input int n, input bit bad_cs);
    logic [7:0]  cs;
    logic [15:0] nn;
    nn = 16'(n);
    cs = model_cs(a, n);
    if (bad_cs) cs = cs + 8'd1;
    send_byte(START, 1'b1, $urandom_range(3, 6));
    chk("busy_after_start", busy, 1);
    send_byte(a[15:8], 1'b1, $urandom_range(3, 6));
    send_byte(a[7:0], 1'b1, $urandom_range(3, 6));
    send_byte(nn[15:8], 1'b1, $urandom_range(3, 6));
    send_byte(nn[7:0], 1'b1, $urandom_range(3, 6));
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a + 16'(i), pay[i]});
      send_byte(pay[i], 1'b1, $urandom_range(3, 6));
    end
    send_byte(cs, 1'b1, 6);
    if (!bad_cs) exp_done++;
    chk("done_count", done_seen, exp_done);
    chk("err_end", err, bad_cs);
    chk("busy_end", busy, 0);
    chk("writes_drained", exp_q.size(), 0);
  endtask

  // ---------------- main ----------------
  initial begin
    // per-cycle compare process
    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (we) begin
            chk("we_while_busy", busy, 1);
            if (exp_q.size() == 0) begin
              chk("unexpected_we", {addr, data_out}, 24'hxxxxxx);
            end else begin
              chk("write", {addr, data_out}, exp_q.pop_front());
            end
            last_addr = addr;
            last_data = data_out;
          end
          if (done) begin
            done_seen++;
            chk("err_on_done", err, 0);
          end
        end
      end
    join_none

    repeat (4) @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_data", data_out, 0);
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: basic two-byte load
    pay[0] = 8'hAA; pay[1] = 8'h55;
    chk("t1_cs_model", model_cs(16'h0100, 2), 8'hFE);
    run_frame(16'h0100, 2, 1'b0);
    chk("t1_last_addr", last_addr, 16'h0101);
    chk("t1_last_data", last_data, 8'h55);

    // 2: address wrap
    pay[0] = 8'h11; pay[1] = 8'h22;
    chk("t2_cs_model", model_cs(16'hFFFF, 2), 8'hCD);
    run_frame(16'hFFFF, 2, 1'b0);
    chk("t2_last_addr", last_addr, 16'h0000);
    chk("t2_last_data", last_data, 8'h22);

    // 3: bad checksum, then a good frame clears err
    pay[0] = 8'h33;
    run_frame(16'h0010, 1, 1'b1);
    chk("t3_err_literal", err, 1);
    pay[0] = 8'h44;
    run_frame(16'h0011, 1, 1'b0);

    // 4: stray byte ignored, zero-length frame
    send_byte(8'h41, 1'b1, 6);
    chk("t4_stray_busy", busy, 0);
    run_frame(16'h0000, 0, 1'b0);

    // 5: framing error inside DATA
    send_byte(START, 1'b1, 4);
    send_byte(8'h00, 1'b1, 4);
    send_byte(8'h20, 1'b1, 4);
    send_byte(8'h00, 1'b1, 4);
    send_byte(8'h03, 1'b1, 4);
    exp_q.push_back({16'h0020, 8'h77});
    send_byte(8'h77, 1'b1, 4);
    send_byte(8'h88, 1'b0, 8);
    chk("t5_err", err, 1);
    chk("t5_busy", busy, 0);
    chk("t5_done", done_seen, exp_done);
    chk("t5_drained", exp_q.size(), 0);
    pay[0] = 8'h9C;
    run_frame(16'h0400, 1, 1'b0);

    // 6a: one-clock glitch
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (60) @(negedge clk);
    chk("t6_glitch_busy", busy, 0);
    chk("t6_glitch_done", done_seen, exp_done);

    // 6b: reset mid-DATA
    send_byte(START, 1'b1, 4);
    send_byte(8'h00, 1'b1, 4);
    send_byte(8'h30, 1'b1, 4);
    send_byte(8'h00, 1'b1, 4);
    send_byte(8'h04, 1'b1, 4);
    exp_q.push_back({16'h0030, 8'h12});
    send_byte(8'h12, 1'b1, 4);
    chk("t6_busy_before_rst", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_addr", addr, 0);
    chk("t6_rst_data", data_out, 0);
    chk("t6_rst_we", we, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_err", err, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_drained", exp_q.size(), 0);

    // randomized frames
    for (int f = 0; f < 16; f++) begin
      int          n;
      logic [15:0] a;
      n = $urandom_range(0, 5);
      a = 16'($urandom);
      if (f % 5 == 0) a = 16'hFFFE;
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      run_frame(a, n, ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
